// File: rtl/mbc_mapper.sv
// Cartridge bank mapper: synchronises the console bus, decodes bank-register writes and serves ROM reads from SPRAM.
// Optional external RAM window is enabled with `define MBC_EXT_RAM_EN.
module mbc_mapper #(
  parameter int ROM_BANK_BITS = 5,
  parameter int RAM_BANK_BITS = 2,
  parameter int SYNC_STAGES   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                bus_A,
  input  logic [7:0]                 bus_D_in,
  input  logic                       bus_nRD,
  input  logic                       bus_nWR,
  input  logic                       load_done,
  input  logic [15:0]                mem_dout,
  output logic [ROM_BANK_BITS+12:0]  mem_addr,
  output logic [7:0]                 bus_D_out,
  output logic                       bus_D_oe,
  output logic                       cpu_reset,
  output logic [ROM_BANK_BITS-1:0]   rom_bank,
  output logic                       ram_we,
  output logic [RAM_BANK_BITS+12:0]  ram_addr,
  output logic [7:0]                 ram_din,
  input  logic [7:0]                 ram_dout
);
  localparam int RBW = (RAM_BANK_BITS > 0) ? RAM_BANK_BITS : 1;

  logic [15:0]            a_sync [SYNC_STAGES];
  logic [7:0]             d_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nwr_sync;
  logic                   nwr_q;
  logic                   wr_strobe;
  logic [15:0]            a_s;
  logic [7:0]             d_s;
  logic                   nwr_s;
  logic                   wr_en;

  assign a_s   = a_sync[SYNC_STAGES-1];
  assign d_s   = d_sync[SYNC_STAGES-1];
  assign nwr_s = nwr_sync[SYNC_STAGES-1];

  // nWR stages reset high so leaving reset with the strobe idle is not seen as an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync[i] <= '0;
        d_sync[i] <= '0;
      end
      nwr_sync  <= '1;
      nwr_q     <= 1'b1;
      wr_strobe <= 1'b0;
    end else begin
      a_sync[0] <= bus_A;
      d_sync[0] <= bus_D_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync[i] <= a_sync[i-1];
        d_sync[i] <= d_sync[i-1];
      end
      nwr_sync  <= {nwr_sync[SYNC_STAGES-2:0], bus_nWR};
      nwr_q     <= nwr_s;
      wr_strobe <= load_done & nwr_s & ~nwr_q;
    end
  end

  assign wr_en = wr_strobe & load_done;

  logic [ROM_BANK_BITS-1:0] rom_sel;
  logic [ROM_BANK_BITS-1:0] bank_sel;
  assign rom_sel  = d_s[ROM_BANK_BITS-1:0];
  assign bank_sel = a_s[14] ? rom_bank : '0;
  assign mem_addr = {bank_sel, a_s[13:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_bank <= ROM_BANK_BITS'(1);
    end else if (wr_en && a_s[15:13] == 3'b001) begin
      rom_bank <= (rom_sel == '0) ? ROM_BANK_BITS'(1) : rom_sel;
    end
  end

  logic [7:0] ram_byte;
  logic       ram_window;

`ifdef MBC_EXT_RAM_EN
  logic           ram_en;
  logic [RBW-1:0] ram_bank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en   <= 1'b0;
      ram_bank <= '0;
    end else if (wr_en) begin
      if (a_s[15:13] == 3'b000) ram_en <= (d_s[3:0] == 4'hA);
      if (a_s[15:13] == 3'b010 && RAM_BANK_BITS > 0) ram_bank <= d_s[RBW-1:0];
    end
  end

  generate
    if (RAM_BANK_BITS > 0) begin : g_bank_addr
      assign ram_addr = {ram_bank, a_s[12:0]};
    end else begin : g_flat_addr
      assign ram_addr = a_s[12:0];
    end
  endgenerate

  assign ram_we     = wr_en & (a_s[15:13] == 3'b101) & ram_en;
  assign ram_din    = d_s;
  assign ram_byte   = ram_en ? ram_dout : 8'hFF;
  assign ram_window = ram_en & (bus_A[15:13] == 3'b101);
`else
  logic unused_ram;
  assign unused_ram = ^{ram_dout, d_s};
  assign ram_we     = 1'b0;
  assign ram_addr   = '0;
  assign ram_din    = '0;
  assign ram_byte   = 8'hFF;
  assign ram_window = 1'b0;
`endif

  // byte select and window flag are delayed one cycle to line up with the memory read latency
  logic a0_q;
  logic ram_sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a0_q      <= 1'b0;
      ram_sel_q <= 1'b0;
      bus_D_out <= 8'hFF;
      cpu_reset <= 1'b1;
    end else begin
      a0_q      <= a_s[0];
      ram_sel_q <= (a_s[15:13] == 3'b101);
      if (ram_sel_q) bus_D_out <= ram_byte;
      else           bus_D_out <= a0_q ? mem_dout[15:8] : mem_dout[7:0];
      cpu_reset <= ~load_done;
    end
  end

  assign bus_D_oe = ~bus_nRD & load_done & (~bus_A[15] | ram_window);

endmodule

// File: tb/tb_mbc_mapper.sv
// Bench for mbc_mapper: directed and random bus cycles scored against a behavioural mapper model.
// Build with +define+MBC_EXT_RAM_EN to also exercise the external RAM window.
module tb_mbc_mapper;
  localparam int RBB = 5;
  localparam int KBB = 2;
  localparam int SS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       bus_A;
  logic [7:0]        bus_D_in;
  logic              bus_nRD;
  logic              bus_nWR;
  logic              load_done;
  logic [15:0]       mem_dout;
  logic [RBB+12:0]   mem_addr;
  logic [7:0]        bus_D_out;
  logic              bus_D_oe;
  logic              cpu_reset;
  logic [RBB-1:0]    rom_bank;
  logic              ram_we;
  logic [KBB+12:0]   ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  mbc_mapper #(.ROM_BANK_BITS(RBB), .RAM_BANK_BITS(KBB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .bus_A(bus_A), .bus_D_in(bus_D_in), .bus_nRD(bus_nRD),
    .bus_nWR(bus_nWR), .load_done(load_done), .mem_dout(mem_dout), .mem_addr(mem_addr),
    .bus_D_out(bus_D_out), .bus_D_oe(bus_D_oe), .cpu_reset(cpu_reset), .rom_bank(rom_bank),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // clock / reset block: 20 MHz
  always #25 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM image: word 0 holds BEEF, others derived from the word address
  function automatic logic [15:0] rom_word(input logic [RBB+12:0] wa);
    logic [7:0] hi, lo;
    if (wa == '0) return 16'hBEEF;
    hi = wa[7:0] ^ 8'(wa >> 13);
    lo = 8'(wa >> 5) ^ 8'h3C;
    return {hi, lo};
  endfunction

  logic [7:0] ram_mem [0:(1<<(KBB+13))-1];
  always @(posedge clk) begin
    mem_dout <= rom_word(mem_addr);
    ram_dout <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_din;
  end

  // reference model state
  int         m_bank;
  bit         m_ram_en;
  int         m_ram_bank;
  logic [7:0] m_ram [0:(1<<(KBB+13))-1];
  int         exp_we_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    logic [RBB-1:0]  bk;
    logic [15:0]     w;
    logic [KBB+12:0] ra;
    if (a[15:13] == 3'b101) begin
      ra = {KBB'(m_ram_bank), a[12:0]};
      return m_ram_en ? m_ram[ra] : 8'hFF;
    end
    bk = (a[15:14] == 2'b01) ? RBB'(m_bank) : '0;
    w  = rom_word({bk, a[13:1]});
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic logic ref_oe(input logic [15:0] a);
    logic ram_ok;
    ram_ok = 1'b0;
`ifdef MBC_EXT_RAM_EN
    ram_ok = m_ram_en && (a[15:13] == 3'b101);
`endif
    return load_done && (!a[15] || ram_ok);
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [7:0] d);
    int m;
    logic [KBB+12:0] ra;
    if (!load_done) return;
    if (a[15:13] == 3'b001) begin
      m = d % (1 << RBB);
      m_bank = (m == 0) ? 1 : m;
    end
`ifdef MBC_EXT_RAM_EN
    if (a[15:13] == 3'b000) m_ram_en = (d[3:0] == 4'hA);
    if (a[15:13] == 3'b010) m_ram_bank = d % (1 << KBB);
    if (a[15:13] == 3'b101 && m_ram_en) begin
      ra = {KBB'(m_ram_bank), a[12:0]};
      m_ram[ra] = d;
      exp_we_cnt++;
    end
`endif
  endtask

  // scoreboard: read responses are due SS+2 cycles after the address is driven
  typedef struct packed {
    logic [31:0] due;
    logic        oe;
    logic [7:0]  data;
    logic        chk_prev;
    logic [7:0]  prev;
  } rd_t;
  rd_t exp_q[$];

  int         we_cnt = 0;
  logic [KBB+12:0] we_addr;
  logic [7:0] we_din;

  always @(negedge clk) begin
    rd_t e;
    if (exp_q.size() > 0) begin
      if (exp_q[0].chk_prev && cyc == int'(exp_q[0].due) - 1)
        check("rd_not_early", {24'h0, bus_D_out}, {24'h0, exp_q[0].prev});
      if (cyc == int'(exp_q[0].due)) begin
        e = exp_q.pop_front();
        check("rd_oe_data", {23'h0, bus_D_oe, bus_D_out}, {23'h0, e.oe, e.data});
      end
    end
    if (ram_we) begin
      we_cnt++;
      we_addr = ram_addr;
      we_din  = ram_din;
    end
  end

  // driver tasks
  bit         last_rd;
  logic [7:0] last_byte;

  task automatic do_read(input logic [15:0] a);
    rd_t e;
    @(negedge clk);
    e.due      = cyc + SS + 2;
    e.data     = ref_read(a);
    e.oe       = ref_oe(a);
    e.chk_prev = last_rd && (last_byte != e.data);
    e.prev     = last_byte;
    exp_q.push_back(e);
    bus_A   = a;
    bus_nRD = 1'b0;
    repeat (SS + 3) @(negedge clk);
    bus_nRD   = 1'b1;
    last_rd   = 1'b1;
    last_byte = e.data;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_A    = a;
    bus_D_in = d;
    bus_nWR  = 1'b0;
    repeat (SS + 2) @(negedge clk);
    bus_nWR = 1'b1;
    repeat (SS + 3) @(negedge clk);
    ref_write(a, d);
    last_rd = 1'b0;
    check("rom_bank", 32'(rom_bank), 32'(m_bank));
    check("ram_we_count", 32'(we_cnt), 32'(exp_we_cnt));
  endtask

  task automatic model_reset();
    m_bank = 1; m_ram_en = 0; m_ram_bank = 0; last_rd = 0;
  endtask

  logic [RBB+12:0] ma_exp;
  logic [15:0]     ra;

  initial begin
    for (int i = 0; i < (1 << (KBB + 13)); i++) begin
      ram_mem[i] = 8'h00;
      m_ram[i]   = 8'h00;
    end
    model_reset();
    exp_we_cnt = 0;
    reset = 1'b1; load_done = 1'b0; bus_A = '0; bus_D_in = '0; bus_nRD = 1'b1; bus_nWR = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rom_bank", 32'(rom_bank), 32'd1);
    check("rst_d_out", 32'(bus_D_out), 32'hFF);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // writes while the image is not loaded are ignored and the console stays in reset
    do_write(16'h2000, 8'h05);
    check("cpu_reset_unloaded", 32'(cpu_reset), 32'd1);
    load_done = 1'b1;
    check("cpu_reset_same_cycle", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    check("cpu_reset_released", 32'(cpu_reset), 32'd0);

    // bank zero maps to one; plain bank select; banked read address
    do_write(16'h2000, 8'h00);
    do_write(16'h2100, 8'h03);
    do_read(16'h4002);
    ma_exp = {RBB'(3), 13'h0001};
    check("mem_addr_bank3", 32'(mem_addr), 32'(ma_exp));
    do_read(16'h0001);
    do_write(16'h2000, 8'h20);
    do_write(16'h3FFF, 8'h1F);
    do_read(16'h7FFE);

    // writes outside the control ranges change nothing
    do_write(16'h8000, 8'h07);
    do_write(16'h9FFF, 8'h02);
    do_write(16'hC000, 8'h04);
    do_write(16'hFFFF, 8'h06);
    do_read(16'h4001);

    // RAM enable, RAM bank and RAM write
    do_write(16'h0000, 8'h0A);
    do_write(16'h4000, 8'h02);
    do_write(16'hA123, 8'h5A);
`ifdef MBC_EXT_RAM_EN
    check("ram_we_addr", 32'(we_addr), 32'h4123);
    check("ram_we_din", 32'(we_din), 32'h5A);
    do_read(16'hA123);
    do_write(16'h0000, 8'h00);
    do_read(16'hA123);
    do_write(16'hA123, 8'h11);
`else
    check("ram_addr_tied", 32'(ram_addr), 32'd0);
    check("ram_din_tied", 32'(ram_din), 32'd0);
`endif

    // load_done falling: console held in reset, bank registers hold, writes ignored
    @(negedge clk);
    load_done = 1'b0;
    check("cpu_reset_before_edge", 32'(cpu_reset), 32'd0);
    @(negedge clk);
    check("cpu_reset_on_unload", 32'(cpu_reset), 32'd1);
    do_write(16'h2000, 8'h07);
    load_done = 1'b1;
    repeat (2) @(negedge clk);

    // reset released with nWR idle: no strobe
    reset = 1'b1; bus_A = 16'h2000; bus_D_in = 8'h0B; bus_nWR = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (SS + 5) @(negedge clk);
    check("no_strobe_after_reset", 32'(rom_bank), 32'd1);

    // reset released with nWR low, then raised: one strobe
    reset = 1'b1; bus_D_in = 8'h09; bus_nWR = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (SS + 2) @(negedge clk);
    bus_nWR = 1'b1;
    repeat (SS + 3) @(negedge clk);
    ref_write(16'h2000, 8'h09);
    check("strobe_after_reset", 32'(rom_bank), 32'(m_bank));

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: do_write(16'h2000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom_range(0, 255)));
        1: do_read(16'($urandom_range(0, 16'h7FFF)));
        2: begin
          ra = $urandom_range(0, 1) ? (16'h8000 | 16'($urandom_range(0, 16'h1FFF)))
                                    : (16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
          do_write(ra, 8'($urandom_range(0, 255)));
        end
        3: begin
          case ($urandom_range(0, 2))
            0: do_write(16'($urandom_range(0, 16'h1FFF)),
                        $urandom_range(0, 1) ? 8'h0A : 8'($urandom_range(0, 255)));
            1: do_write(16'h4000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom_range(0, 255)));
            default: do_write(16'hA000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom_range(0, 255)));
          endcase
        end
        default: begin
`ifdef MBC_EXT_RAM_EN
          do_read(16'hA000 | 16'($urandom_range(0, 16'h1FFF)));
`else
          do_read(16'h4000 | 16'($urandom_range(0, 16'h3FFF)));
`endif
        end
      endcase
    end

    repeat (SS + 5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
